// File: rtl/fifo_read_ptr_sync_ctrl_pkg.sv
// Shared FIFO pointer helpers: gray/binary conversion and the default pointer width.
// Both FIFO controllers import this so they use the same pointer encoding.
package fifo_read_ptr_sync_ctrl_pkg;

    localparam int DEFAULT_FIFO_PTR_BITS_CNT = 9;

    // Conversions work on a fixed wide word; callers zero-extend and truncate.
    localparam int GRAY_FN_W = 32;

    function automatic logic [GRAY_FN_W-1:0] bin_to_gray(input logic [GRAY_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_FN_W-1:0] gray_to_bin(input logic [GRAY_FN_W-1:0] gray);
        logic [GRAY_FN_W-1:0] bin;
        bin[GRAY_FN_W-1] = gray[GRAY_FN_W-1];
        for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing into this clock domain.
module cdc_gray_sync #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Placement tools keep these flops adjacent to maximise metastability settling time.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/fifo_read_ptr_sync_ctrl.sv
// Read-side FIFO pointer controller: synchronises the write pointer, tracks the tail,
// drives lookahead BRAM addressing and reports level/almost-empty/error flags.
module fifo_read_ptr_sync_ctrl
    import fifo_read_ptr_sync_ctrl_pkg::*;
#(
    parameter int INT_FIFO_PTR_BITS_CNT   = DEFAULT_FIFO_PTR_BITS_CNT,
    parameter int INT_SYNC_STAGES         = 2,
    parameter int INT_ALMOST_EMPTY_THRESH = 4
) (
    input  logic                             rd_clk,
    input  logic                             rd_rst,
    input  logic [INT_FIFO_PTR_BITS_CNT:0]   i_wr_grayptr,
    input  logic                             i_dready,
    output logic                             o_valid,
    output logic                             o_rd_en,
    output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_rd_intptr,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_rd_grayptr,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_level,
    output logic                             o_almost_empty,
    output logic                             o_underflow,
    output logic                             o_ptr_err
);

    localparam int P = INT_FIFO_PTR_BITS_CNT;
    localparam int W = INT_FIFO_PTR_BITS_CNT + 1;
    localparam logic [W-1:0] DEPTH  = {1'b1, {P{1'b0}}};
    localparam logic [W-1:0] THRESH = W'(INT_ALMOST_EMPTY_THRESH);

    logic [W-1:0] wr_gray_sync;
    logic [W-1:0] wr_bin;
    logic [W-1:0] tail;
    logic [W-1:0] tail_next;
    logic [W-1:0] diff;
    logic [W-1:0] level_next;
    logic         pop;
    logic         over;

    cdc_gray_sync #(
        .WIDTH (W),
        .STAGES(INT_SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk(rd_clk),
        .rst(rd_rst),
        .d  (i_wr_grayptr),
        .q  (wr_gray_sync)
    );

    // Address runs one pop ahead so the BRAM's one-cycle latency lines up with o_valid.
    always_comb begin
        wr_bin      = W'(gray_to_bin(GRAY_FN_W'(wr_gray_sync)));
        pop         = o_valid & i_dready;
        tail_next   = tail + W'(pop);
        o_rd_intptr = tail_next[P-1:0];
        diff        = wr_bin - tail_next;
        over        = (diff > DEPTH);
        level_next  = over ? DEPTH : diff;
    end

    assign o_rd_en = ~rd_rst;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            tail           <= '0;
            o_valid        <= 1'b0;
            o_rd_grayptr   <= '0;
            o_level        <= '0;
            o_almost_empty <= 1'b1;
            o_underflow    <= 1'b0;
            o_ptr_err      <= 1'b0;
        end else begin
            tail           <= tail_next;
            o_valid        <= (wr_bin != tail_next);
            o_rd_grayptr   <= W'(bin_to_gray(GRAY_FN_W'(tail_next)));
            o_level        <= level_next;
            o_almost_empty <= (level_next <= THRESH);
            if (i_dready && !o_valid) begin
                o_underflow <= 1'b1;
            end
            if (over) begin
                o_ptr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_ptr_sync_ctrl.sv
// Directed self-checking bench for fifo_read_ptr_sync_ctrl at P=4, SYNC=2, THRESH=4.
module tb_fifo_read_ptr_sync_ctrl;

    logic       rd_clk = 1'b0;
    logic       rd_rst;
    logic [4:0] i_wr_grayptr;
    logic       i_dready;
    logic       o_valid;
    logic       o_rd_en;
    logic [3:0] o_rd_intptr;
    logic [4:0] o_rd_grayptr;
    logic [4:0] o_level;
    logic       o_almost_empty;
    logic       o_underflow;
    logic       o_ptr_err;

    int errors = 0;
    int checks = 0;

    fifo_read_ptr_sync_ctrl #(
        .INT_FIFO_PTR_BITS_CNT  (4),
        .INT_SYNC_STAGES        (2),
        .INT_ALMOST_EMPTY_THRESH(4)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .i_wr_grayptr  (i_wr_grayptr),
        .i_dready      (i_dready),
        .o_valid       (o_valid),
        .o_rd_en       (o_rd_en),
        .o_rd_intptr   (o_rd_intptr),
        .o_rd_grayptr  (o_rd_grayptr),
        .o_level       (o_level),
        .o_almost_empty(o_almost_empty),
        .o_underflow   (o_underflow),
        .o_ptr_err     (o_ptr_err)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset();
        rd_rst = 1'b1; i_wr_grayptr = '0; i_dready = 1'b0;
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0d want 0", o_valid); end
        checks++; if (o_level !== 5'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", o_level); end
        checks++; if (o_almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_almost_empty got %0d want 1", o_almost_empty); end
        checks++; if (o_underflow !== 1'b0 || o_ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got uf=%0d pe=%0d want 0 0", o_underflow, o_ptr_err); end
        checks++; if (o_rd_grayptr !== 5'd0) begin errors++; $display("[TB] FAIL reset_grayptr got %0d want 0", o_rd_grayptr); end
        checks++; if (o_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got %0d want 0", o_rd_en); end
        rd_rst = 1'b0;
        #1;
        checks++; if (o_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL run_rd_en got %0d want 1", o_rd_en); end
    endtask

    task automatic test_write_visible();
        i_wr_grayptr = gray(5'd3);
        repeat (2) @(negedge rd_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early_valid got %0d want 0", o_valid); end
        @(negedge rd_clk);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_valid got %0d want 1", o_valid); end
        checks++; if (o_level !== 5'd3) begin errors++; $display("[TB] FAIL write3_level got %0d want 3", o_level); end
        checks++; if (o_almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL write3_almost_empty got %0d want 1", o_almost_empty); end
    endtask

    task automatic test_drain();
        i_dready = 1'b1;
        #1;
        checks++; if (o_rd_intptr !== 4'd1) begin errors++; $display("[TB] FAIL drain_addr1 got %0d want 1", o_rd_intptr); end
        @(negedge rd_clk);
        checks++; if (o_rd_intptr !== 4'd2 || o_level !== 5'd2) begin errors++; $display("[TB] FAIL drain_addr2 got addr=%0d lvl=%0d want 2 2", o_rd_intptr, o_level); end
        @(negedge rd_clk);
        checks++; if (o_rd_intptr !== 4'd3 || o_level !== 5'd1) begin errors++; $display("[TB] FAIL drain_addr3 got addr=%0d lvl=%0d want 3 1", o_rd_intptr, o_level); end
        @(negedge rd_clk);
        checks++; if (o_valid !== 1'b0 || o_level !== 5'd0) begin errors++; $display("[TB] FAIL drain_empty got v=%0d lvl=%0d want 0 0", o_valid, o_level); end
        checks++; if (o_rd_intptr !== 4'd3) begin errors++; $display("[TB] FAIL drain_hold_addr got %0d want 3", o_rd_intptr); end
        checks++; if (o_rd_grayptr !== 5'd2) begin errors++; $display("[TB] FAIL drain_grayptr got %0d want 2", o_rd_grayptr); end
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("[TB] FAIL underflow_early got %0d want 0", o_underflow); end
        @(negedge rd_clk);
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_set got %0d want 1", o_underflow); end
        checks++; if (o_rd_intptr !== 4'd3) begin errors++; $display("[TB] FAIL underflow_no_move got %0d want 3", o_rd_intptr); end
        i_dready = 1'b0;
    endtask

    task automatic test_stream();
        logic [4:0] wr_model = 5'd3;
        logic [4:0] mt = 5'd3;
        logic [4:0] prev_gray = gray(5'd3);
        int written = 0;
        int pops = 0;
        bit wrapped = 0;
        i_dready = 1'b1;
        for (int cyc = 0; cyc < 200 && pops < 40; cyc++) begin
            if (o_rd_grayptr !== prev_gray) begin
                checks++;
                if ($countones(o_rd_grayptr ^ prev_gray) != 1) begin
                    errors++; $display("[TB] FAIL stream_gray_step got %0d from %0d want one bit", o_rd_grayptr, prev_gray);
                end
                prev_gray = o_rd_grayptr;
            end
            if (o_valid === 1'b1) begin
                checks++; if (o_rd_intptr !== 4'(mt + 5'd1)) begin errors++; $display("[TB] FAIL stream_addr got %0d want %0d", o_rd_intptr, 4'(mt + 5'd1)); end
                checks++; if (o_rd_grayptr !== gray(mt)) begin errors++; $display("[TB] FAIL stream_grayptr got %0d want %0d", o_rd_grayptr, gray(mt)); end
                mt = mt + 5'd1;
                pops++;
                if (mt == 5'd0) wrapped = 1;
            end
            if (written < 40) begin
                wr_model = wr_model + 5'd1;
                written++;
                i_wr_grayptr = gray(wr_model);
            end
            @(negedge rd_clk);
        end
        checks++; if (pops != 40) begin errors++; $display("[TB] FAIL stream_pop_count got %0d want 40", pops); end
        checks++; if (!wrapped || mt != 5'd11) begin errors++; $display("[TB] FAIL stream_wrap got wrap=%0d tail=%0d want 1 11", wrapped, mt); end
        checks++; if (o_valid !== 1'b0 || o_level !== 5'd0) begin errors++; $display("[TB] FAIL stream_end got v=%0d lvl=%0d want 0 0", o_valid, o_level); end
        i_dready = 1'b0;
    endtask

    task automatic test_full();
        rd_rst = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0; i_dready = 1'b0; i_wr_grayptr = gray(5'd16);
        repeat (3) @(negedge rd_clk);
        checks++; if (o_level !== 5'd16 || o_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_level got lvl=%0d v=%0d want 16 1", o_level, o_valid); end
        checks++; if (o_ptr_err !== 1'b0 || o_underflow !== 1'b0) begin errors++; $display("[TB] FAIL full_flags got pe=%0d uf=%0d want 0 0", o_ptr_err, o_underflow); end
        checks++; if (o_almost_empty !== 1'b0) begin errors++; $display("[TB] FAIL full_almost_empty got %0d want 0", o_almost_empty); end
        i_dready = 1'b1;
        @(negedge rd_clk);
        i_dready = 1'b0;
        checks++; if (o_level !== 5'd15 || o_ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL full_pop got lvl=%0d pe=%0d want 15 0", o_level, o_ptr_err); end
    endtask

    task automatic test_ptr_err();
        rd_rst = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0; i_wr_grayptr = gray(5'd20);
        repeat (3) @(negedge rd_clk);
        checks++; if (o_ptr_err !== 1'b1) begin errors++; $display("[TB] FAIL ptr_err_set got %0d want 1", o_ptr_err); end
        checks++; if (o_level !== 5'd16 || o_valid !== 1'b1) begin errors++; $display("[TB] FAIL ptr_err_level got lvl=%0d v=%0d want 16 1", o_level, o_valid); end
        i_wr_grayptr = gray(5'd4);
        repeat (3) @(negedge rd_clk);
        checks++; if (o_ptr_err !== 1'b1 || o_level !== 5'd4) begin errors++; $display("[TB] FAIL ptr_err_sticky got pe=%0d lvl=%0d want 1 4", o_ptr_err, o_level); end
        checks++; if (o_almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL thresh_level4 got %0d want 1", o_almost_empty); end
    endtask

    task automatic test_reset_mid();
        rd_rst = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0; i_wr_grayptr = '0; i_dready = 1'b1;
        @(negedge rd_clk);
        i_dready = 1'b0; i_wr_grayptr = gray(5'd7);
        repeat (3) @(negedge rd_clk);
        checks++; if (o_level !== 5'd7 || o_underflow !== 1'b1) begin errors++; $display("[TB] FAIL mid_setup got lvl=%0d uf=%0d want 7 1", o_level, o_underflow); end
        i_dready = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b1;
        @(negedge rd_clk);
        checks++; if (o_valid !== 1'b0 || o_level !== 5'd0 || o_almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_state got v=%0d lvl=%0d ae=%0d want 0 0 1", o_valid, o_level, o_almost_empty); end
        checks++; if (o_underflow !== 1'b0 || o_ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_flags got uf=%0d pe=%0d want 0 0", o_underflow, o_ptr_err); end
        checks++; if (o_rd_grayptr !== 5'd0 || o_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ptr got g=%0d en=%0d want 0 0", o_rd_grayptr, o_rd_en); end
        rd_rst = 1'b0; i_dready = 1'b0;
        @(negedge rd_clk);
        checks++; if (o_valid !== 1'b0 || o_level !== 5'd0) begin errors++; $display("[TB] FAIL post_reset_empty got v=%0d lvl=%0d want 0 0", o_valid, o_level); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write_visible();
        test_drain();
        test_stream();
        test_full();
        test_ptr_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
